// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: producer-side handshake and serial line of the UART transmitter.
interface uart_tx_frame_if #(parameter int NBITS = 8);
  logic             ticks;
  logic [NBITS-1:0] Tx_Data;
  logic             Tx_en;
  logic             Tx_ready;
  logic             Tx_busy;
  logic             Tx;
  logic             Tx_done;
  modport master (output ticks, Tx_Data, Tx_en, input Tx_ready, Tx_busy, Tx, Tx_done);
  modport slave (input ticks, Tx_Data, Tx_en, output Tx_ready, Tx_busy, Tx, Tx_done);
endinterface

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: tick-driven UART transmitter with a one-word holding register.
// Define UART_TX_PARITY_EN to add a parity bit after the data (PARITY_ODD selects odd).
module uart_tx_frame #(
  parameter int NBITS = 8,
  parameter int RATE = 16,
  parameter int STOP_BITS = 1,
  parameter bit PARITY_ODD = 1'b0
) (
  input logic clk,
  input logic rst,
  uart_tx_frame_if.slave tx_if
);
  localparam int TW = $clog2(RATE);
  localparam int BW = $clog2(NBITS + 1);
  localparam int SW = $clog2(STOP_BITS * RATE);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic parity_q;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  logic unused_par;
  assign unused_par = PARITY_ODD;
`endif
  state_t state_q;
  logic [TW-1:0] tick_q;
  logic [BW-1:0] bit_q;
  logic [SW-1:0] stop_q;
  logic [NBITS-1:0] shift_q, hold_q, hold_d;
  logic hold_valid_q, hold_valid_d, tx_q, done_q;
  logic tick_last, bit_last, stop_last, xfer, accept;
  // a pending word moves into the shifter at the IDLE tick or the last stop tick
  always_comb begin
    tick_last = tick_q == TW'(RATE - 1);
    bit_last = bit_q == BW'(NBITS - 1);
    stop_last = stop_q == SW'(STOP_BITS * RATE - 1);
    xfer = tx_if.ticks && hold_valid_q && (state_q == IDLE || (state_q == STOP && stop_last));
    accept = tx_if.Tx_en && !hold_valid_q;
    hold_valid_d = xfer ? 1'b0 : accept ? 1'b1 : hold_valid_q;
    hold_d = accept ? tx_if.Tx_Data : hold_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q <= '0;
      bit_q <= '0;
      stop_q <= '0;
      shift_q <= '0;
      hold_q <= '0;
      hold_valid_q <= 1'b0;
      tx_q <= 1'b1;
      done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      hold_q <= hold_d;
      hold_valid_q <= hold_valid_d;
      done_q <= tx_if.ticks && state_q == STOP && stop_last;
      if (xfer) begin
        shift_q <= hold_q;
`ifdef UART_TX_PARITY_EN
        parity_q <= ^hold_q ^ PARITY_ODD;
`endif
        tx_q <= 1'b0;
        tick_q <= '0;
        stop_q <= '0;
        state_q <= START;
      end else if (tx_if.ticks) begin
        case (state_q)
          START: begin
            tick_q <= tick_last ? '0 : tick_q + 1'b1;
            bit_q <= '0;
            if (tick_last) begin
              tx_q <= shift_q[0];
              state_q <= DATA;
            end
          end
          DATA: begin
            tick_q <= tick_last ? '0 : tick_q + 1'b1;
            if (tick_last) begin
              shift_q <= shift_q >> 1;
              bit_q <= bit_q + 1'b1;
`ifdef UART_TX_PARITY_EN
              tx_q <= bit_last ? parity_q : shift_q[1];
              state_q <= bit_last ? PARITY : DATA;
`else
              tx_q <= bit_last ? 1'b1 : shift_q[1];
              state_q <= bit_last ? STOP : DATA;
`endif
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            tick_q <= tick_last ? '0 : tick_q + 1'b1;
            if (tick_last) begin
              tx_q <= 1'b1;
              state_q <= STOP;
            end
          end
`endif
          STOP: begin
            stop_q <= stop_last ? '0 : stop_q + 1'b1;
            if (stop_last) state_q <= IDLE;
          end
          default: tx_q <= 1'b1;
        endcase
      end
    end
  end
  assign tx_if.Tx = tx_q;
  assign tx_if.Tx_done = done_q;
  assign tx_if.Tx_busy = state_q != IDLE;
  assign tx_if.Tx_ready = !hold_valid_q;
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: table-driven frames plus scoreboarded line monitor for two configurations.
module tb_uart_tx_frame;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FR_A = 16 * (1 + 8 + P + 1);
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  uart_tx_frame_if #(.NBITS(8)) ia();
  uart_tx_frame_if #(.NBITS(7)) ib();
  uart_tx_frame #(.NBITS(8), .RATE(16), .STOP_BITS(1), .PARITY_ODD(1'b0)) dut_a (.clk(clk), .rst(rst), .tx_if(ia.slave));
  uart_tx_frame #(.NBITS(7), .RATE(4), .STOP_BITS(2), .PARITY_ODD(1'b0)) dut_b (.clk(clk), .rst(rst), .tx_if(ib.slave));

  int vectors = 0;
  int miscompares = 0;
  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  int k[2], total[2], dones[2], tickn[2], last_done[2], prev_done[2];
  bit inf[2];
  logic [15:0] fbits[2];
  logic [8:0] qa[$];
  logic [8:0] qb[$];
  logic stk[2] = '{1'b0, 1'b0};
  logic srst = 1'b1;

  // one call per clk, after the edge; tk/ rst are the values that edge saw
  task automatic mon(input int id, input int rate, input int nb, input int sb,
                     input logic tx, input logic done, input logic busy, input logic tk);
    logic [8:0] w;
    logic par;
    if (tk) tickn[id]++;
    if (inf[id] && tk) begin
      k[id]++;
      if (k[id] == total[id]) begin
        chk("done_at_frame_end", done, 1);
        dones[id]++;
        prev_done[id] = last_done[id];
        last_done[id] = tickn[id];
        inf[id] = 1'b0;
      end else chk("done_mid_frame", done, 0);
    end else chk("done_quiet", done, 0);
    if (!inf[id] && tx == 1'b0) begin
      chk("start_on_tick", tk, 1);
      chk("frame_expected", ((id == 0) ? qa.size() : qb.size()) != 0, 1);
      if (((id == 0) ? qa.size() : qb.size()) != 0) begin
        if (id == 0) w = qa.pop_front();
        else w = qb.pop_front();
        fbits[id] = '1;
        fbits[id][0] = 1'b0;
        par = 1'b0;
        for (int i = 0; i < nb; i++) begin
          fbits[id][1 + i] = w[i];
          par ^= w[i];
        end
        if (P == 1) fbits[id][1 + nb] = par;
        total[id] = (1 + nb + P + sb) * rate;
        k[id] = 0;
        inf[id] = 1'b1;
      end
    end else if (inf[id]) chk("line_bit", tx, fbits[id][k[id] / rate]);
    else chk("line_idle", tx, 1);
    chk("busy", busy, inf[id]);
  endtask

  always @(negedge clk) begin
    logic ta, tb, r;
    r = srst;
    srst = rst;
    ta = stk[0];
    stk[0] = ia.ticks;
    tb = stk[1];
    stk[1] = ib.ticks;
    if (r) begin
      inf[0] = 1'b0;
      inf[1] = 1'b0;
    end else begin
      mon(0, 16, 8, 1, ia.Tx, ia.Tx_done, ia.Tx_busy, ta);
      mon(1, 4, 7, 2, ib.Tx, ib.Tx_done, ib.Tx_busy, tb);
    end
  end

  initial begin
    int cnt;
    cnt = 0;
    ia.ticks = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cnt = (cnt + 1) % 4;
      ia.ticks = cnt == 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] d, input bit push);
    int n;
    n = 0;
    while (!ia.Tx_ready && n < 3000) begin
      step();
      n++;
    end
    chk("a_ready_before_send", ia.Tx_ready, 1);
    ia.Tx_en = 1'b1;
    ia.Tx_Data = d;
    if (push) qa.push_back({1'b0, d});
    step();
    ia.Tx_en = 1'b0;
    chk("a_ready_fell", ia.Tx_ready, 0);
  endtask

  task automatic send_b(input logic [6:0] d);
    int n;
    n = 0;
    while (!ib.Tx_ready && n < 3000) begin
      step();
      n++;
    end
    chk("b_ready_before_send", ib.Tx_ready, 1);
    ib.Tx_en = 1'b1;
    ib.Tx_Data = d;
    qb.push_back({2'b0, d});
    step();
    ib.Tx_en = 1'b0;
    chk("b_ready_fell", ib.Tx_ready, 0);
  endtask

  task automatic wait_dones(input int id, input int n);
    int c;
    c = 0;
    while (dones[id] < n && c < 6000) begin
      step();
      c++;
    end
    chk("done_count", dones[id], n);
  endtask

  typedef struct {
    logic [7:0] data;
    bit wait_end;
    int gap;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int d0, c, nexp;
    tbl[0] = '{8'h55, 1'b1, 0};
    tbl[1] = '{8'h00, 1'b1, 0};
    tbl[2] = '{8'hFF, 1'b1, 0};
    tbl[3] = '{8'h81, 1'b1, 0};
    tbl[4] = '{8'hA5, 1'b0, 0};
    tbl[5] = '{8'h3C, 1'b1, FR_A};
    ia.Tx_en = 1'b0;
    ia.Tx_Data = '0;
    ib.Tx_en = 1'b0;
    ib.Tx_Data = '0;
    ib.ticks = 1'b1;
    repeat (3) step();
    chk("rst_tx_a", ia.Tx, 1);
    chk("rst_done_a", ia.Tx_done, 0);
    chk("rst_busy_a", ia.Tx_busy, 0);
    chk("rst_ready_a", ia.Tx_ready, 1);
    chk("rst_tx_b", ib.Tx, 1);
    chk("rst_ready_b", ib.Tx_ready, 1);
    rst = 1'b0;
    repeat (5) step();
    // single frames, then a back-to-back pair whose done pulses must be one frame apart
    nexp = 0;
    for (int i = 0; i < 6; i++) begin
      send_a(tbl[i].data, 1'b1);
      nexp++;
      if (tbl[i].wait_end) begin
        wait_dones(0, nexp);
        step();
        chk("idle_busy", ia.Tx_busy, 0);
        chk("idle_ready", ia.Tx_ready, 1);
        if (tbl[i].gap != 0) chk("stream_done_spacing", last_done[0] - prev_done[0], tbl[i].gap);
      end
    end
    // backpressure: 0x11 queued behind 0x5A, 0x22/0x33 dropped
    d0 = dones[0];
    send_a(8'h5A, 1'b1);
    c = 0;
    while (!(ia.Tx_ready && ia.Tx_busy) && c < 100) begin
      step();
      c++;
    end
    chk("bp_frame_started", ia.Tx_busy && ia.Tx_ready, 1);
    ia.Tx_en = 1'b1;
    ia.Tx_Data = 8'h11;
    qa.push_back(9'h011);
    step();
    chk("bp_accept_11", ia.Tx_ready, 0);
    ia.Tx_Data = 8'h22;
    step();
    chk("bp_hold_22", ia.Tx_ready, 0);
    ia.Tx_Data = 8'h33;
    step();
    ia.Tx_en = 1'b0;
    chk("bp_hold_33", ia.Tx_ready, 0);
    c = 0;
    while (!ia.Tx_ready && c < 3000) begin
      step();
      c++;
    end
    chk("bp_release_on_done", ia.Tx_done, 1);
    chk("bp_no_gap", ia.Tx, 0);
    // collision: Tx_en held across the transfer edge must not be taken
    send_a(8'h77, 1'b1);
    ia.Tx_en = 1'b1;
    ia.Tx_Data = 8'h33;
    c = 0;
    while (!ia.Tx_ready && c < 3000) begin
      step();
      c++;
    end
    ia.Tx_en = 1'b0;
    chk("collision_at_done", ia.Tx_done, 1);
    step();
    chk("collision_dropped", ia.Tx_ready, 1);
    wait_dones(0, d0 + 3);
    repeat (200) step();
    chk("bp_no_extra_frame", dones[0], d0 + 3);
    chk("bp_queue_empty", qa.size(), 0);
    // reset during data bit 3 with a word waiting in the holding register
    send_a(8'hC3, 1'b1);
    c = 0;
    while (!(inf[0] && k[0] / 16 == 4) && c < 3000) begin
      step();
      c++;
    end
    chk("rst_reached_bit3", inf[0] && k[0] / 16 == 4, 1);
    send_a(8'h99, 1'b0);
    d0 = dones[0];
    rst = 1'b1;
    step();
    chk("midrst_tx", ia.Tx, 1);
    chk("midrst_ready", ia.Tx_ready, 1);
    chk("midrst_busy", ia.Tx_busy, 0);
    chk("midrst_done", ia.Tx_done, 0);
    rst = 1'b0;
    repeat (300) step();
    chk("midrst_no_done", dones[0], d0);
    chk("midrst_queue_empty", qa.size(), 0);
    send_a(8'hF0, 1'b1);
    wait_dones(0, d0 + 1);
    // 7 data bits, 2 stop bits, RATE 4, ticks every clk: 40 clk per frame
    send_b(7'h7F);
    c = 0;
    while (ib.Tx && c < 100) begin
      step();
      c++;
    end
    chk("b_start_seen", ib.Tx, 0);
    c = 0;
    while (!ib.Tx_done && c < 200) begin
      step();
      c++;
    end
    chk("b_frame_len", c, 40);
    send_b(7'h2A);
    wait_dones(1, 2);
    step();
    chk("b_idle_busy", ib.Tx_busy, 0);
    chk("final_queue_a", qa.size(), 0);
    chk("final_queue_b", qb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
